// File: rtl/const_reg_pkg.sv
// Shared types and helpers for the runtime-programmable constant register bank.
// The CONST_PARITY_EN build option uses even_parity() for the stream sideband.
package const_reg_pkg;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  localparam int NUM_REGS_DEFAULT = 4;
  localparam int PARITY_MAX_W     = 64;

  // Width of a register index; a single register still needs one bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_WIDTH = idx_bits(NUM_REGS_DEFAULT);

  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage : const_reg_pkg

// File: rtl/const_reg_bank.sv
// Shadow/active constant arrays with config write decode, write-to-commit
// forwarding and flat packing of the active set.
module const_reg_bank
  import const_reg_pkg::*;
#(
  parameter int CONST_WIDTH = 10,
  parameter int NUM_REGS    = 4,
  parameter int ADDR_WIDTH  = 2,
  parameter int RESET_VAL   = 10
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst,
  input  logic                            wr_en,
  input  logic [ADDR_WIDTH-1:0]           wr_addr,
  input  logic [CONST_WIDTH-1:0]          wr_data,
  input  logic                            commit_apply,
  output logic [NUM_REGS*CONST_WIDTH-1:0] dout,
  output logic [CONST_WIDTH-1:0]          head_next
);

  localparam logic [CONST_WIDTH-1:0] RESET_TR = CONST_WIDTH'(RESET_VAL);

  logic [CONST_WIDTH-1:0] shadow     [NUM_REGS];
  logic [CONST_WIDTH-1:0] active     [NUM_REGS];
  logic [CONST_WIDTH-1:0] shadow_fwd [NUM_REGS];

  // Addresses >= NUM_REGS match no entry, so such writes fall away here.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      shadow_fwd[i] = (wr_en && (wr_addr == ADDR_WIDTH'(i))) ? wr_data : shadow[i];
    end
  end

  always_comb begin
    dout = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      dout[i*CONST_WIDTH +: CONST_WIDTH] = active[i];
    end
  end

  // Register 0 as it will be after this edge, so a stream started alongside
  // a commit carries the new value on its first beat.
  assign head_next = commit_apply ? shadow_fwd[0] : active[0];

  // NOTE: both arrays are reset explicitly because RESET_VAL is architectural
  // state; the bank is small flops, not a RAM, so the reset is cheap and legal.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= RESET_TR;
        active[i] <= RESET_TR;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= shadow_fwd[i];
        if (commit_apply) begin
          active[i] <= shadow_fwd[i];
        end
      end
    end
  end

endmodule : const_reg_bank

// File: rtl/const_reg_ctrl.sv
// Constant register controller: commit sequencing and AXI-Stream readout of
// the active set. Define CONST_PARITY_EN to add m_axis_tuser and parity_err.
module const_reg_ctrl
  import const_reg_pkg::*;
#(
  parameter int CONST_WIDTH = 10,
  parameter int NUM_REGS    = 4,
  parameter int ADDR_WIDTH  = 2,
  parameter int RESET_VAL   = 10
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [ADDR_WIDTH-1:0]           cfg_addr,
  input  logic [CONST_WIDTH-1:0]          cfg_data,
  input  logic                            commit,
  input  logic                            stream_start,
  output logic                            busy,
  output logic [NUM_REGS*CONST_WIDTH-1:0] dout,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [CONST_WIDTH-1:0]          m_axis_tdata,
  output logic                            m_axis_tlast
`ifdef CONST_PARITY_EN
  ,
  output logic                            m_axis_tuser,
  output logic                            parity_err
`endif
);

  localparam int IW = idx_bits(NUM_REGS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REGS - 1);

  state_t                 state;
  logic [IW-1:0]          idx;
  logic [IW-1:0]          beat_idx;
  logic                   pending;
  logic                   wr_en;
  logic                   handshake;
  logic                   is_last;
  logic                   commit_apply;
  logic                   load_en;
  logic [CONST_WIDTH-1:0] load_val;
  logic [CONST_WIDTH-1:0] head_next;

  assign cfg_ready = ~ap_rst;
  assign wr_en     = cfg_valid & cfg_ready;
  assign handshake = m_axis_tvalid & m_axis_tready;
  assign is_last   = (idx == LAST_IDX);
  assign busy      = (state == S_STREAM) | pending;

  // A commit seen in the final handshake cycle is honoured like a pending one.
  assign commit_apply = ((state == S_IDLE) && commit) ||
                        ((state == S_STREAM) && handshake && is_last && (pending || commit));

  always_comb begin
    beat_idx = is_last ? idx : idx + IW'(1);
    load_en  = ((state == S_IDLE) && stream_start) ||
               ((state == S_STREAM) && handshake && !is_last);
    load_val = (state == S_IDLE) ? head_next
                                 : dout[int'(beat_idx)*CONST_WIDTH +: CONST_WIDTH];
  end

  const_reg_bank #(
    .CONST_WIDTH (CONST_WIDTH),
    .NUM_REGS    (NUM_REGS),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .RESET_VAL   (RESET_VAL)
  ) u_bank (
    .ap_clk       (ap_clk),
    .ap_rst       (ap_rst),
    .wr_en        (wr_en),
    .wr_addr      (cfg_addr),
    .wr_data      (cfg_data),
    .commit_apply (commit_apply),
    .dout         (dout),
    .head_next    (head_next)
  );

  // NOTE: every flop here uses <=, so all next-state terms see pre-edge
  // values and the later pending clear cleanly overrides the earlier set.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state         <= S_IDLE;
      idx           <= '0;
      pending       <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      if (load_en) begin
        m_axis_tdata <= load_val;
      end
      case (state)
        S_IDLE: begin
          if (stream_start) begin
            state         <= S_STREAM;
            idx           <= '0;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= 1'b0;
          end
        end
        S_STREAM: begin
          if (commit) begin
            pending <= 1'b1;
          end
          if (handshake) begin
            if (is_last) begin
              state         <= S_IDLE;
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              pending       <= 1'b0;
            end else begin
              idx          <= beat_idx;
              m_axis_tlast <= (beat_idx == LAST_IDX);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CONST_PARITY_EN
  localparam logic RESET_PAR =
    even_parity(PARITY_MAX_W'(CONST_WIDTH'(RESET_VAL)));

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      m_axis_tuser <= 1'b0;
      parity_err   <= 1'b0;
    end else begin
      if (load_en) begin
        m_axis_tuser <= even_parity(PARITY_MAX_W'(load_val));
      end
      if (wr_en && (int'(cfg_addr) < NUM_REGS) && (cfg_data == '0) && RESET_PAR) begin
        parity_err <= 1'b1;
      end
    end
  end
`endif

endmodule : const_reg_ctrl

// File: tb/tb_const_reg_ctrl.sv
// Directed self-checking bench for const_reg_ctrl (default build plus a
// NUM_REGS=3 instance for out-of-range address and short-burst checks).
module tb_const_reg_ctrl;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        cfg_valid, cfg_ready, commit, stream_start, busy;
  logic [1:0]  cfg_addr;
  logic [9:0]  cfg_data;
  logic [39:0] dout;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [9:0]  m_axis_tdata;

  logic        s_cfg_valid, s_cfg_ready, s_commit, s_stream_start, s_busy;
  logic [1:0]  s_cfg_addr;
  logic [9:0]  s_cfg_data;
  logic [29:0] s_dout;
  logic        s_tvalid, s_tready, s_tlast;
  logic [9:0]  s_tdata;

`ifdef CONST_PARITY_EN
  logic m_axis_tuser, parity_err, s_tuser, s_parity_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 ap_clk = ~ap_clk;

  const_reg_ctrl dut (
    .ap_clk        (ap_clk),
    .ap_rst        (ap_rst),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_addr      (cfg_addr),
    .cfg_data      (cfg_data),
    .commit        (commit),
    .stream_start  (stream_start),
    .busy          (busy),
    .dout          (dout),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast)
`ifdef CONST_PARITY_EN
    ,
    .m_axis_tuser  (m_axis_tuser),
    .parity_err    (parity_err)
`endif
  );

  const_reg_ctrl #(.NUM_REGS(3)) dut3 (
    .ap_clk        (ap_clk),
    .ap_rst        (ap_rst),
    .cfg_valid     (s_cfg_valid),
    .cfg_ready     (s_cfg_ready),
    .cfg_addr      (s_cfg_addr),
    .cfg_data      (s_cfg_data),
    .commit        (s_commit),
    .stream_start  (s_stream_start),
    .busy          (s_busy),
    .dout          (s_dout),
    .m_axis_tvalid (s_tvalid),
    .m_axis_tready (s_tready),
    .m_axis_tdata  (s_tdata),
    .m_axis_tlast  (s_tlast)
`ifdef CONST_PARITY_EN
    ,
    .m_axis_tuser  (s_tuser),
    .parity_err    (s_parity_err)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [9:0] data, input logic with_commit);
    cfg_valid = 1'b1;
    cfg_addr  = addr;
    cfg_data  = data;
    commit    = with_commit;
    tick();
    cfg_valid = 1'b0;
    commit    = 1'b0;
  endtask

  // Drains one 4-beat burst with a repeating 7-cycle tready pattern (bit i = cycle i).
  task automatic run_burst(input string name, input logic [9:0] e0, input logic [9:0] e1,
                           input logic [9:0] e2, input logic [9:0] e3, input logic [6:0] pat);
    logic [9:0] exp_b [4];
    logic [9:0] held;
    logic       stalled;
    int         k;
    int         cyc;
    exp_b = '{e0, e1, e2, e3};
    held  = '0;
    k     = 0;
    cyc   = 0;
    while (k < 4 && cyc < 40) begin
      m_axis_tready = pat[cyc % 7];
      stalled = 1'b0;
      if (m_axis_tvalid && m_axis_tready) begin
        check({name, "_data"}, 64'(m_axis_tdata), 64'(exp_b[k]));
        check({name, "_last"}, 64'(m_axis_tlast), 64'(k == 3));
        k++;
      end else if (m_axis_tvalid) begin
        held    = m_axis_tdata;
        stalled = 1'b1;
      end
      tick();
      if (stalled) check({name, "_hold"}, 64'(m_axis_tdata), 64'(held));
      cyc++;
    end
    check({name, "_beats"}, 64'(k), 64'(4));
    check({name, "_idle"}, 64'(m_axis_tvalid), 64'(0));
    m_axis_tready = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    ap_rst = 1'b1;
    cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0; commit = 1'b0; stream_start = 1'b0;
    m_axis_tready = 1'b1;
    s_cfg_valid = 1'b0; s_cfg_addr = '0; s_cfg_data = '0; s_commit = 1'b0;
    s_stream_start = 1'b0; s_tready = 1'b1;
    tick(); tick();
    ap_rst = 1'b0;
    #1;

    // Reset state
    check("rst_dout", 64'(dout), 64'({4{10'd10}}));
    check("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ready", 64'(cfg_ready), 64'(1));

    // Stream of reset values, first beat one cycle after the pulse
    stream_start = 1'b1; tick(); stream_start = 1'b0;
    check("s0_first_valid", 64'(m_axis_tvalid), 64'(1));
    check("s0_busy", 64'(busy), 64'(1));
    run_burst("s0", 10'd10, 10'd10, 10'd10, 10'd10, 7'b1111111);

    // Shadow writes stay invisible until commit
    cfg_write(2'd0, 10'd1, 1'b0);
    cfg_write(2'd1, 10'd2, 1'b0);
    cfg_write(2'd2, 10'd3, 1'b0);
    cfg_write(2'd3, 10'd4, 1'b0);
    check("no_commit_dout", 64'(dout), 64'({4{10'd10}}));
    commit = 1'b1; tick(); commit = 1'b0;
    check("commit_dout", 64'(dout), 64'({10'd4, 10'd3, 10'd2, 10'd1}));

    // Write and commit in the same cycle forwards the write
    cfg_write(2'd2, 10'd99, 1'b1);
    check("fwd_dout", 64'(dout), 64'({10'd4, 10'd99, 10'd2, 10'd1}));

    // Back-pressured burst: tready 1,0,0,1,1,0,1
    stream_start = 1'b1; tick(); stream_start = 1'b0;
    run_burst("s1", 10'd1, 10'd2, 10'd99, 10'd4, 7'b1011001);

    // Commit mid-stream is deferred until the tlast handshake
    cfg_write(2'd0, 10'd7, 1'b0);
    stream_start = 1'b1; tick(); stream_start = 1'b0;
    m_axis_tready = 1'b0; commit = 1'b1; tick(); commit = 1'b0;
    check("mid_busy", 64'(busy), 64'(1));
    check("mid_hold", 64'(m_axis_tdata), 64'(1));
    check("mid_frozen", 64'(dout), 64'({10'd4, 10'd99, 10'd2, 10'd1}));
    run_burst("s2", 10'd1, 10'd2, 10'd99, 10'd4, 7'b1111111);
    check("pend_dout", 64'(dout), 64'({10'd4, 10'd99, 10'd2, 10'd7}));
    check("pend_busy", 64'(busy), 64'(0));

    // Commit together with stream_start: stream carries the new values
    cfg_write(2'd1, 10'd5, 1'b0);
    commit = 1'b1; stream_start = 1'b1; tick(); commit = 1'b0; stream_start = 1'b0;
    check("cs_dout", 64'(dout), 64'({10'd4, 10'd99, 10'd5, 10'd7}));
    run_burst("s3", 10'd7, 10'd5, 10'd99, 10'd4, 7'b1111111);

    // Reset in mid-burst aborts the stream and restores RESET_VAL
    stream_start = 1'b1; tick(); stream_start = 1'b0;
    m_axis_tready = 1'b1;
    check("ab_beat0", 64'(m_axis_tdata), 64'(7));
    tick();
    check("ab_beat1", 64'(m_axis_tdata), 64'(5));
    ap_rst = 1'b1; tick(); ap_rst = 1'b0;
    check("ab_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("ab_tlast", 64'(m_axis_tlast), 64'(0));
    check("ab_busy", 64'(busy), 64'(0));
    check("ab_dout", 64'(dout), 64'({4{10'd10}}));
    commit = 1'b1; tick(); commit = 1'b0;
    check("ab_shadow", 64'(dout), 64'({4{10'd10}}));

    // NUM_REGS=3: address 3 is discarded, address 1 lands
    s_cfg_valid = 1'b1; s_cfg_addr = 2'd3; s_cfg_data = 10'd55; s_commit = 1'b1;
    tick();
    s_cfg_valid = 1'b0; s_commit = 1'b0;
    check("n3_oob", 64'(s_dout), 64'({3{10'd10}}));
    s_cfg_valid = 1'b1; s_cfg_addr = 2'd1; s_cfg_data = 10'd55; s_commit = 1'b1;
    tick();
    s_cfg_valid = 1'b0; s_commit = 1'b0;
    check("n3_wr", 64'(s_dout), 64'({10'd10, 10'd55, 10'd10}));

    // NUM_REGS=3 burst ends with tlast on the third beat
    s_stream_start = 1'b1; tick(); s_stream_start = 1'b0;
    check("n3_busy", 64'(s_busy), 64'(1));
    check("n3_ready", 64'(s_cfg_ready), 64'(1));
    for (int i = 0; i < 3; i++) begin
      check("n3_valid", 64'(s_tvalid), 64'(1));
      check("n3_data", 64'(s_tdata), 64'((i == 1) ? 10'd55 : 10'd10));
      check("n3_last", 64'(s_tlast), 64'(i == 2));
      tick();
    end
    check("n3_idle", 64'(s_tvalid), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_const_reg_ctrl
